// File: rtl/spi_responder.sv
// spi_responder
// -------------
// Chip-side end of the control-board serial link: the 8-bit address / 8-bit
// data SPI protocol (mode 0, MSB first). spi_clk and spi_mosi are oversampled
// in the local clk domain. Register writes are committed to a small register
// file, and register reads are returned on spi_miso during the data byte.
// The same register file is readable locally through lcl_addr/lcl_rdata.
//
// Ports
//   clk          IP clock, all flops on its rising edge
//   rst          synchronous active-high reset
//   spi_clk      serial clock from the driver (idles low, asynchronous to clk)
//   spi_mosi     serial data from the driver
//   spi_miso     serial data to the driver
//   lcl_addr     local read index
//   lcl_rdata    register[lcl_addr], registered, 0x00 when out of range
//   wr_strobe    one-cycle pulse when a write commits
//   wr_addr      index of the last committed write (held)
//   wr_data      data of the last committed write (held)
//   frame_error  one-cycle pulse when a partial frame is abandoned on timeout
//
// Parameters
//   N_REGS        implemented registers, indices 0..N_REGS-1 (N_REGS <= 128)
//   IDLE_TIMEOUT  clk cycles without an spi_clk edge before a partial frame
//                 is abandoned

module spi_responder #(
   parameter int N_REGS       = 16,
   parameter int IDLE_TIMEOUT = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_clk,
   input  logic       spi_mosi,
   output logic       spi_miso,
   input  logic [6:0] lcl_addr,
   output logic [7:0] lcl_rdata,
   output logic       wr_strobe,
   output logic [6:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       frame_error
);

   localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
   localparam int TO_W  = $clog2(IDLE_TIMEOUT + 1);

   localparam logic [7:0]      N_REGS_L = 8'(N_REGS);
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(IDLE_TIMEOUT - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ADDR   = 2'd1;
   localparam logic [1:0] ST_DATA   = 2'd2;
   localparam logic [1:0] ST_COMMIT = 2'd3;

   logic [7:0] regs [N_REGS];

   logic spi_clk_meta;
   logic spi_clk_sync;
   logic spi_clk_prev;
   logic mosi_meta;
   logic mosi_sync;

   logic clk_rise;
   logic clk_fall;

   logic [1:0]      state;
   logic [4:0]      bit_cnt;
   logic [7:0]      rx_shift;
   logic [7:0]      tx_shift;
   logic            cur_wr;
   logic [6:0]      cur_idx;
   logic [TO_W-1:0] to_cnt;

   logic [7:0] rx_byte;
   logic [6:0] rx_idx;
   logic       rx_idx_ok;
   logic       cur_idx_ok;
   logic       lcl_addr_ok;
   logic [7:0] rd_val;
   logic       timeout;

   // Two-flop synchronizers on both serial inputs; the extra spi_clk flop
   // holds the previous synchronized level so edges can be detected. Both
   // paths have equal depth, so mosi stays aligned with its clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         spi_clk_meta <= 1'b0;
         spi_clk_sync <= 1'b0;
         spi_clk_prev <= 1'b0;
         mosi_meta    <= 1'b0;
         mosi_sync    <= 1'b0;
      end else begin
         spi_clk_meta <= spi_clk;
         spi_clk_sync <= spi_clk_meta;
         spi_clk_prev <= spi_clk_sync;
         mosi_meta    <= spi_mosi;
         mosi_sync    <= mosi_meta;
      end
   end

   assign clk_rise = spi_clk_sync & ~spi_clk_prev;
   assign clk_fall = ~spi_clk_sync & spi_clk_prev;

   // The byte as it will look once the bit arriving on this rise is shifted
   // in. On the 8th rise it is {wr, idx}, on the 16th rise the data byte.
   assign rx_byte = {rx_shift[6:0], mosi_sync};
   assign rx_idx  = rx_byte[6:0];

   assign rx_idx_ok   = ({1'b0, rx_idx}   < N_REGS_L);
   assign cur_idx_ok  = ({1'b0, cur_idx}  < N_REGS_L);
   assign lcl_addr_ok = ({1'b0, lcl_addr} < N_REGS_L);

   assign rd_val  = rx_idx_ok ? regs[rx_idx[IDX_W-1:0]] : 8'h00;
   assign timeout = (to_cnt == TO_LAST);

   // spi_miso is only driven during the data byte; tx_shift empties to zero
   // as it is shifted, and COMMIT/IDLE force the line low after the 16th rise.
   assign spi_miso = (state == ST_DATA) & tx_shift[7];

   // Frame sequencer, timeout supervision and register-file writes.
   // The register write, wr_strobe and wr_addr/wr_data all update on the
   // 16th rise edge, so wr_strobe is high during the COMMIT cycle and the
   // register already holds the new value while wr_strobe is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         bit_cnt     <= 5'd0;
         rx_shift    <= 8'h00;
         tx_shift    <= 8'h00;
         cur_wr      <= 1'b0;
         cur_idx     <= 7'd0;
         to_cnt      <= '0;
         frame_error <= 1'b0;
         wr_strobe   <= 1'b0;
         wr_addr     <= 7'd0;
         wr_data     <= 8'h00;
         for (int i = 0; i < N_REGS; i++) begin
            regs[i] <= 8'h00;
         end
      end else begin
         frame_error <= 1'b0;
         wr_strobe   <= 1'b0;

         if (clk_rise) begin
            rx_shift <= rx_byte;
         end

         // Idle counter only runs while a frame is partially received.
         if (clk_rise || clk_fall || state == ST_IDLE || state == ST_COMMIT) begin
            to_cnt <= '0;
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (clk_rise) begin
                  state   <= ST_ADDR;
                  bit_cnt <= 5'd1;
               end
            end

            ST_ADDR: begin
               if (clk_rise) begin
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt == 5'd7) begin
                     state    <= ST_DATA;
                     cur_wr   <= rx_byte[7];
                     cur_idx  <= rx_idx;
                     tx_shift <= rd_val;
                  end
               end else if (timeout) begin
                  state       <= ST_IDLE;
                  bit_cnt     <= 5'd0;
                  frame_error <= 1'b1;
               end
            end

            ST_DATA: begin
               if (clk_rise) begin
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt == 5'd15) begin
                     state <= ST_COMMIT;
                     if (cur_wr && cur_idx_ok) begin
                        regs[cur_idx[IDX_W-1:0]] <= rx_byte;
                        wr_strobe <= 1'b1;
                        wr_addr   <= cur_idx;
                        wr_data   <= rx_byte;
                     end
                  end
               end else if (clk_fall) begin
                  tx_shift <= {tx_shift[6:0], 1'b0};
               end else if (timeout) begin
                  state       <= ST_IDLE;
                  bit_cnt     <= 5'd0;
                  tx_shift    <= 8'h00;
                  frame_error <= 1'b1;
               end
            end

            default: begin
               // COMMIT lasts one cycle; a rise seen here is bit 1 of the
               // next frame so back-to-back frames lose nothing.
               if (clk_rise) begin
                  state   <= ST_ADDR;
                  bit_cnt <= 5'd1;
               end else begin
                  state   <= ST_IDLE;
                  bit_cnt <= 5'd0;
               end
            end
         endcase
      end
   end

   // Local read port, one cycle of latency, zero for unimplemented indices.
   always_ff @(posedge clk) begin
      if (rst) begin
         lcl_rdata <= 8'h00;
      end else begin
         lcl_rdata <= lcl_addr_ok ? regs[lcl_addr[IDX_W-1:0]] : 8'h00;
      end
   end

endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder
// ----------------
// Directed bench for spi_responder: drives SPI mode-0 frames bit by bit from
// the clk domain and compares observed outputs against hand-computed values.

module tb_spi_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic       spi_clk;
   logic       spi_mosi;
   logic       spi_miso;
   logic [6:0] lcl_addr;
   logic [7:0] lcl_rdata;
   logic       wr_strobe;
   logic [6:0] wr_addr;
   logic [7:0] wr_data;
   logic       frame_error;

   int checks = 0;
   int errors = 0;

   int         strobe_cnt = 0;
   int         fe_cnt     = 0;
   logic       strobe_d   = 1'b0;
   logic [7:0] rdata_after_strobe = 8'h00;

   spi_responder #(
      .N_REGS      (16),
      .IDLE_TIMEOUT(256)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .spi_clk    (spi_clk),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso),
      .lcl_addr   (lcl_addr),
      .lcl_rdata  (lcl_rdata),
      .wr_strobe  (wr_strobe),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .frame_error(frame_error)
   );

   always #5 clk = ~clk;

   // Pulse counters and the local read value one cycle after each strobe.
   always @(negedge clk) begin
      if (strobe_d) rdata_after_strobe = lcl_rdata;
      if (wr_strobe) strobe_cnt++;
      if (frame_error) fe_cnt++;
      strobe_d = wr_strobe;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Sends the first nbits of frame MSB first. spi_miso is sampled at the end
   // of each high phase: samples after rises 8..15 form data_bits (MSB first),
   // any high sample elsewhere sets stray.
   task automatic applyStimulus(input logic [15:0] frame, input int nbits,
                                input int half, output logic [7:0] data_bits,
                                output logic stray);
      data_bits = 8'h00;
      stray     = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = frame[15-i];
         repeat (half) @(negedge clk);
         spi_clk = 1'b1;
         repeat (half) @(negedge clk);
         if (i >= 7 && i <= 14) data_bits[14-i] = spi_miso;
         else if (spi_miso) stray = 1'b1;
         spi_clk = 1'b0;
      end
      spi_mosi = 1'b0;
   endtask

   task automatic readLocal(input logic [6:0] a, output logic [7:0] d);
      @(negedge clk);
      lcl_addr = a;
      @(negedge clk);
      @(negedge clk);
      d = lcl_rdata;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [7:0] miso_bits;
      logic       stray;
      logic [7:0] rd;
      int         base;
      int         fe_first;
      int         fe_pulses;

      rst      = 1'b1;
      spi_clk  = 1'b0;
      spi_mosi = 1'b0;
      lcl_addr = 7'd5;
      idle(4);

      // Reset values
      checkOutput("rst_miso",      32'(spi_miso),    32'h0);
      checkOutput("rst_lcl_rdata", 32'(lcl_rdata),   32'h00);
      checkOutput("rst_wr_strobe", 32'(wr_strobe),   32'h0);
      checkOutput("rst_wr_addr",   32'(wr_addr),     32'h0);
      checkOutput("rst_wr_data",   32'(wr_data),     32'h00);
      checkOutput("rst_frame_err", 32'(frame_error), 32'h0);
      rst = 1'b0;
      idle(4);

      // Write 0x85,0xA5
      base = strobe_cnt;
      applyStimulus(16'h85A5, 16, 4, miso_bits, stray);
      idle(10);
      checkOutput("w1_strobes",    32'(strobe_cnt - base), 32'd1);
      checkOutput("w1_wr_addr",    32'(wr_addr),           32'd5);
      checkOutput("w1_wr_data",    32'(wr_data),           32'hA5);
      checkOutput("w1_miso_old",   32'(miso_bits),         32'h00);
      checkOutput("w1_rdata_next", 32'(rdata_after_strobe), 32'hA5);
      readLocal(7'd5, rd);
      checkOutput("w1_reg5",       32'(rd),                32'hA5);

      // Read 0x05 returns 1,0,1,0,0,1,0,1
      base = strobe_cnt;
      applyStimulus(16'h0500, 16, 4, miso_bits, stray);
      idle(10);
      checkOutput("r1_miso_bits",  32'(miso_bits),         32'hA5);
      checkOutput("r1_miso_stray", 32'(stray),             32'h0);
      checkOutput("r1_strobes",    32'(strobe_cnt - base), 32'd0);
      readLocal(7'd5, rd);
      checkOutput("r1_reg5",       32'(rd),                32'hA5);

      // Partial frame then idle: single frame_error 256 cycles after last edge.
      // The fall reaches the edge detector 3 clk edges after being driven, so
      // the pulse is seen on the 259th falling clk edge.
      base = strobe_cnt;
      applyStimulus(16'h8AFF, 5, 4, miso_bits, stray);
      fe_first  = 0;
      fe_pulses = 0;
      for (int n = 1; n <= 300; n++) begin
         @(negedge clk);
         if (frame_error) begin
            fe_pulses++;
            if (fe_first == 0) fe_first = n;
         end
      end
      checkOutput("to_pulses",  32'(fe_pulses),          32'd1);
      checkOutput("to_cycle",   32'(fe_first),           32'd259);
      checkOutput("to_strobes", 32'(strobe_cnt - base),  32'd0);
      readLocal(7'd10, rd);
      checkOutput("to_reg10",   32'(rd),                 32'h00);

      // Full write after the aborted frame
      base = strobe_cnt;
      applyStimulus(16'h833C, 16, 4, miso_bits, stray);
      idle(10);
      checkOutput("w2_strobes", 32'(strobe_cnt - base), 32'd1);
      checkOutput("w2_wr_addr", 32'(wr_addr),           32'd3);
      checkOutput("w2_wr_data", 32'(wr_data),           32'h3C);
      readLocal(7'd3, rd);
      checkOutput("w2_reg3",    32'(rd),                32'h3C);

      // Write to unimplemented index 31
      base = strobe_cnt;
      applyStimulus(16'h9FFF, 16, 4, miso_bits, stray);
      idle(10);
      checkOutput("oor_strobes", 32'(strobe_cnt - base), 32'd0);
      checkOutput("oor_miso",    32'(miso_bits),         32'h00);
      checkOutput("oor_stray",   32'(stray),             32'h0);
      checkOutput("oor_wr_addr", 32'(wr_addr),           32'd3);
      readLocal(7'd31, rd);
      checkOutput("oor_lcl31",   32'(rd),                32'h00);
      readLocal(7'd15, rd);
      checkOutput("oor_reg15",   32'(rd),                32'h00);
      applyStimulus(16'h1F00, 16, 4, miso_bits, stray);
      idle(10);
      checkOutput("oor_read31",  32'(miso_bits),         32'h00);

      // Reset after 12 bits of a write frame
      lcl_addr = 7'd5;
      idle(3);
      base = strobe_cnt;
      applyStimulus(16'h8177, 12, 4, miso_bits, stray);
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      fe_cnt = 0;
      @(negedge clk);
      checkOutput("mid_lcl_rdata", 32'(lcl_rdata),   32'h00);
      checkOutput("mid_wr_addr",   32'(wr_addr),     32'd0);
      checkOutput("mid_wr_data",   32'(wr_data),     32'h00);
      checkOutput("mid_miso",      32'(spi_miso),    32'h0);
      idle(300);
      checkOutput("mid_strobes",   32'(strobe_cnt - base), 32'd0);
      checkOutput("mid_frame_err", 32'(fe_cnt),      32'd0);
      readLocal(7'd1, rd);
      checkOutput("mid_reg1",      32'(rd),          32'h00);
      readLocal(7'd5, rd);
      checkOutput("mid_reg5",      32'(rd),          32'h00);

      // Back-to-back writes to register 2
      base = strobe_cnt;
      applyStimulus(16'h8211, 16, 4, miso_bits, stray);
      checkOutput("b2b_first_miso",  32'(miso_bits), 32'h00);
      applyStimulus(16'h8222, 16, 4, miso_bits, stray);
      idle(10);
      checkOutput("b2b_second_miso", 32'(miso_bits),          32'h11);
      checkOutput("b2b_strobes",     32'(strobe_cnt - base),  32'd2);
      checkOutput("b2b_wr_data",     32'(wr_data),            32'h22);
      readLocal(7'd2, rd);
      checkOutput("b2b_reg2",        32'(rd),                 32'h22);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
